// File: rtl/issue_queue_collapse.sv
// rtl/issue_queue_collapse.sv - collapsing age-ordered issue queue with windowed grants
module issue_queue_collapse #(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 32,
    parameter int ISSUE_W = 4,
    parameter int DISP_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [DISP_W-1:0]          disp_valid,
    input  logic [DISP_W*WIDTH-1:0]    disp_data,
    output logic                       disp_ready,
    input  logic [ISSUE_W-1:0]         issue_grant,
    output logic [ISSUE_W-1:0]         win_valid,
    output logic [ISSUE_W*WIDTH-1:0]   win_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH+1);

    logic [CW-1:0]    count_q, count_n;
    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [WIDTH-1:0] slot_n [DEPTH];
    logic [DEPTH-1:0] grant_ext;
    logic [DISP_W-1:0] disp_acc;

    // Status depends only on the registered count, so no input reaches an output.
    assign count      = count_q;
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign disp_ready = (count_q <= CW'(DEPTH - DISP_W));
    assign disp_acc   = disp_valid & {DISP_W{disp_ready}};
    assign grant_ext  = DEPTH'(issue_grant & win_valid);

    for (genvar i = 0; i < ISSUE_W; i++) begin : g_win
        assign win_valid[i]               = (count_q > CW'(i));
        assign win_data[i*WIDTH +: WIDTH] = win_valid[i] ? slot_q[i] : '0;
    end

    always_comb begin
        logic [CW-1:0]    removed;
        logic [CW-1:0]    added;
        logic [CW-1:0]    dest [DEPTH];
        logic [DEPTH-1:0] survive;
        logic [CW-1:0]    lane_pos [DISP_W];

        removed = '0;
        for (int j = 0; j < DEPTH; j++) begin
            survive[j] = (CW'(j) < count_q) && !grant_ext[j];
            dest[j]    = CW'(j) - removed;
            removed    = removed + CW'(grant_ext[j]);
        end

        // New entries are packed behind the survivors in ascending lane order.
        added = '0;
        for (int l = 0; l < DISP_W; l++) begin
            lane_pos[l] = count_q - removed + added;
            added       = added + CW'(disp_acc[l]);
        end

        for (int k = 0; k < DEPTH; k++) begin
            slot_n[k] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (survive[j] && dest[j] == CW'(k)) begin
                    slot_n[k] = slot_q[j];
                end
            end
            for (int l = 0; l < DISP_W; l++) begin
                if (disp_acc[l] && lane_pos[l] == CW'(k)) begin
                    slot_n[k] = disp_data[l*WIDTH +: WIDTH];
                end
            end
        end

        count_n = count_q - removed + added;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
        end else if (flush) begin
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            count_q <= count_n;
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= slot_n[k];
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_collapse.sv
// tb/tb_issue_queue_collapse.sv - scoreboard bench for issue_queue_collapse
module tb_issue_queue_collapse;

    localparam int DEPTH   = 8;
    localparam int WIDTH   = 32;
    localparam int ISSUE_W = 4;
    localparam int DISP_W  = 2;
    localparam int CW      = $clog2(DEPTH+1);

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     flush = 1'b0;
    logic [DISP_W-1:0]        disp_valid = '0;
    logic [DISP_W*WIDTH-1:0]  disp_data = '0;
    logic                     disp_ready;
    logic [ISSUE_W-1:0]       issue_grant = '0;
    logic [ISSUE_W-1:0]       win_valid;
    logic [ISSUE_W*WIDTH-1:0] win_data;
    logic [CW-1:0]            count;
    logic                     full;
    logic                     empty;

    issue_queue_collapse #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .ISSUE_W(ISSUE_W), .DISP_W(DISP_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready),
        .issue_grant(issue_grant), .win_valid(win_valid), .win_data(win_data),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0]            cnt;
        logic [ISSUE_W-1:0]       wv;
        logic [ISSUE_W*WIDTH-1:0] wd;
        logic                     full;
        logic                     empty;
        logic                     rdy;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;
    int n_step  = 0;
    logic [WIDTH-1:0] mq[$];
    exp_t exp_q[$];

    localparam logic [WIDTH-1:0] VA = 32'hA000_000A, VB = 32'hB000_000B, VC = 32'hC000_000C;
    localparam logic [WIDTH-1:0] VD = 32'hD000_000D, VE = 32'hE000_000E, VF = 32'hF000_000F;
    localparam logic [WIDTH-1:0] VG = 32'h1000_0016, VH = 32'h1000_0017, VX = 32'h2000_0024;
    localparam logic [WIDTH-1:0] VY = 32'h2000_0025, VZ = 32'h2000_0026, VP = 32'h3000_0030;
    localparam logic [WIDTH-1:0] VQ = 32'h3000_0031;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.cnt = CW'(mq.size());
        e.wv  = '0;
        e.wd  = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (i < mq.size()) begin
                e.wv[i] = 1'b1;
                e.wd[i*WIDTH +: WIDTH] = mq[i];
            end
        end
        e.full  = (mq.size() == DEPTH);
        e.empty = (mq.size() == 0);
        e.rdy   = (DEPTH - mq.size()) >= DISP_W;
        return e;
    endfunction

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq({tag, " scoreboard_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, " count"},      count,      e.cnt);
            check_eq({tag, " win_valid"},  win_valid,  e.wv);
            check_eq({tag, " win_data"},   win_data,   e.wd);
            check_eq({tag, " full"},       full,       e.full);
            check_eq({tag, " empty"},      empty,      e.empty);
            check_eq({tag, " disp_ready"}, disp_ready, e.rdy);
        end
    endtask

    task automatic step(input logic [1:0] dv, input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                        input logic [3:0] gr, input logic fl);
        logic [WIDTH-1:0] nq[$];
        logic rdy;
        @(negedge clk);
        disp_valid  = dv;
        disp_data   = {d1, d0};
        issue_grant = gr;
        flush       = fl;
        rdy = (DEPTH - mq.size()) >= DISP_W;
        if (fl) begin
            mq.delete();
        end else begin
            nq = {};
            foreach (mq[i]) begin
                if (!(i < ISSUE_W && gr[i])) nq.push_back(mq[i]);
            end
            if (rdy && dv[0]) nq.push_back(d0);
            if (rdy && dv[1]) nq.push_back(d1);
            mq = nq;
        end
        exp_q.push_back(model_exp());
        @(posedge clk);
        #1;
        n_step++;
        compare_outputs($sformatf("step%0d", n_step));
        disp_valid  = '0;
        issue_grant = '0;
        flush       = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(model_exp());
        compare_outputs("reset");
        rst_n = 1'b1;

        // Fill to full, then an ignored dispatch while full
        step(2'b11, VA, VB, 4'b0000, 1'b0);
        step(2'b11, VC, VD, 4'b0000, 1'b0);
        step(2'b11, VE, VF, 4'b0000, 1'b0);
        step(2'b11, VG, VH, 4'b0000, 1'b0);
        step(2'b11, VX, VY, 4'b0000, 1'b0);
        check_eq("full_hold count", count, 8);

        // Interleaved grant on a full queue
        step(2'b00, 0, 0, 4'b0101, 1'b0);
        check_eq("grant0101 window", win_data, {VF, VE, VD, VB});

        // Full window grant with same-cycle dispatch
        step(2'b00, 0, 0, 4'b0000, 1'b1);
        step(2'b11, VA, VB, 4'b0000, 1'b0);
        step(2'b11, VC, VD, 4'b0000, 1'b0);
        step(2'b11, VE, VF, 4'b0000, 1'b0);
        step(2'b11, VX, VY, 4'b1111, 1'b0);
        check_eq("grant1111 window", win_data, {VY, VX, VF, VE});

        // Lane packing and grants on invalid slots
        step(2'b00, 0, 0, 4'b0000, 1'b1);
        step(2'b10, 0, VZ, 4'b0000, 1'b0);
        check_eq("lane_pack slot0", win_data[WIDTH-1:0], VZ);
        step(2'b00, 0, 0, 4'b1110, 1'b0);

        // Flush beats grant and dispatch
        step(2'b11, VA, VB, 4'b0000, 1'b0);
        step(2'b11, VC, VD, 4'b0000, 1'b0);
        step(2'b01, VE, 0, 4'b0000, 1'b0);
        step(2'b11, VP, VQ, 4'b0001, 1'b1);

        // Asynchronous reset between edges
        step(2'b11, VA, VB, 4'b0000, 1'b0);
        step(2'b11, VC, VD, 4'b0000, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        exp_q.push_back(model_exp());
        compare_outputs("async_reset");
        #1 rst_n = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            step(2'($urandom_range(0, 3)), $urandom, $urandom,
                 4'($urandom_range(0, 15)), ($urandom_range(0, 24) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_queue_collapse.md
Name: issue_queue_collapse

Overview:
- Parametrised collapsing issue queue: stores dispatched instruction entries in age order (slot 0 = oldest).
- Presents the oldest ISSUE_W entries as the issue window to the checkers.
- Each cycle it removes the granted window entries, compacts the survivors toward slot 0 and appends new dispatches behind them.
- It generalises the fixed 4-entry compaction index select into a stateful queue of arbitrary depth, window width and dispatch width.

Parameters:
- DEPTH, 8, number of queue slots; must be ≥ ISSUE_W and ≥ DISP_W.
- WIDTH, 32, payload bits per entry.
- ISSUE_W, 4, issue window size (oldest slots visible to checkers).
- DISP_W, 2, dispatch lanes per cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries.
- disp_valid  in  DISP_W  per-lane dispatch request.
- disp_data  in  DISP_W*WIDTH  lane k payload at bits [k*WIDTH +: WIDTH].
- disp_ready  out  1  queue can accept a full dispatch group this cycle.
- issue_grant  in  ISSUE_W  checker says window slot i leaves this cycle.
- win_valid  out  ISSUE_W  window slot i holds a valid entry.
- win_data  out  ISSUE_W*WIDTH  window payloads, slot i at [i*WIDTH +: WIDTH].
- count  out  $clog2(DEPTH+1)  number of valid entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count = 0, all slot valids = 0, all stored payloads = 0.
  - Outputs: win_valid = 0, win_data = 0, empty = 1, full = 0, disp_ready = 1.
- Valid entries always occupy slots 0..count-1 contiguously. There are no holes.
- disp_ready = (DEPTH - count) ≥ DISP_W.
  - It is computed from registered count only. It takes no credit for same-cycle grants.
- Dispatch is accepted only when disp_ready = 1.
  - If disp_ready = 0, disp_valid is ignored and nothing is written.
- Effective grant g[i] = issue_grant[i] & win_valid[i]. Grants on invalid slots are ignored.
- Next-state computation, all in one cycle:
  - R = popcount(g).
  - Each surviving slot j moves to slot j - (number of g[i] set with i < j). Relative age order is preserved. Slots ≥ ISSUE_W shift down by R.
  - Accepted valid dispatch lanes are packed in ascending lane order (invalid lanes skipped). They are written at slots count-R, count-R+1, ...
  - count_next = count - R + popcount(accepted disp_valid).
- Latency:
  - A grant in cycle N removes the entry at edge N+1.
  - A dispatch in cycle N is visible at edge N+1, in the window if its slot < ISSUE_W.
  - No combinational path from disp_* or issue_grant to any output.
- win_data for a slot with win_valid = 0 is driven 0.
- Slots ≥ count_next are cleared to valid = 0. Their payload is don't-care but must not appear on win_data.
- flush = 1:
  - At the next edge count = 0 and all valids = 0.
  - Dispatch and grants in the flush cycle are discarded.
  - flush has priority over everything except rst_n.
- Simultaneous full grant and dispatch: handled in the same cycle with no bubble. The window refills from deeper slots and new entries.
- Full queue with no grants: disp_ready = 0 and the contents hold unchanged.
- Asserting rst_n mid-operation clears immediately, independent of clk.
- Illegal grant or dispatch state cannot corrupt count. count never exceeds DEPTH and never underflows.

Test Plan:
1. Reset → count = 0, empty = 1, full = 0, disp_ready = 1, win_valid = 0000, win_data = 0.
2. Dispatch pairs (A,B), (C,D), (E,F) on consecutive cycles, no grants → count = 6, window = A,B,C,D, disp_ready = 1. Then dispatch (G,H) → count = 8, full = 1, disp_ready = 0. A further disp_valid = 11 is ignored and count stays 8.
3. Queue A..H, issue_grant = 0101 → next cycle window = B,D,E,F, count = 6, slots 4,5 = G,H.
4. Queue A..F (count = 6), issue_grant = 1111 with dispatch (X,Y) in the same cycle → window = E,F,X,Y, count = 4.
5. Empty queue, disp_valid = 10 with lane1 = Z → slot 0 = Z, win_valid = 0001, count = 1. issue_grant = 1110 on this state → no effect, count stays 1.
6. Queue A..E, flush = 1 together with grant 0001 and dispatch (P,Q) → count = 0, win_valid = 0000, empty = 1. Repeat with rst_n pulsed low between clock edges → outputs clear immediately.
